// File: rtl/fetch_buffer_if.sv
// Fetch-buffer bus definitions: selector result codes and the bundle of
// handshake/data signals between the fetch stage, instruction memory,
// backend control and the frontend selector.

package fetch_buffer_pkg;
  // Selector result codes
  localparam logic [1:0] RES_INSERT_NOP = 2'd0;
  localparam logic [1:0] RES_POP_DATA   = 2'd1;
  localparam logic [1:0] RES_POP_BUF    = 2'd2;
endpackage

interface fetch_buffer_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [1:0]  result;
  logic        req;
  logic [31:0] cpc;
  logic [31:0] data;
  logic [31:0] bpc;
  logic [31:0] bf;
  logic        sel_en;

  // Fetch stage view
  modport slave (
    input  stall, redirect, redirect_pc, imem_valid, imem_data, result, req,
    output imem_addr, cpc, data, bpc, bf, sel_en
  );

  // Environment view (backend, imem, selector)
  modport master (
    output stall, redirect, redirect_pc, imem_valid, imem_data, result, req,
    input  imem_addr, cpc, data, bpc, bf, sel_en
  );
endinterface

// File: rtl/fetch_buffer.sv
// Front-end fetch stage: owns the fetch PC and a one-entry instruction
// buffer, presents fetched (cpc/data) and buffered (bpc/bf) words to the
// selector and applies the selector's decision to advance/refill.

module fetch_buffer_chk (
  input logic       clk,
  input logic       rst,
  input logic       in_run,
  input logic       adv,
  input logic [1:0] result
);
  // An advancing RUN cycle must carry one of the three defined selector codes
  property p_result_known;
    @(posedge clk) disable iff (rst) (in_run && adv) |-> (result != 2'd3);
  endproperty
  a_result_known: assert property (p_result_known);
endmodule

module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  fetch_buffer_if.slave bus
);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] bpc_q, bpc_d;
  logic [31:0] bf_q, bf_d;
  logic        adv;

  // Redirect beats stall, stall beats an imem wait state
  assign adv = ~bus.redirect & ~bus.stall & bus.imem_valid;

  assign bus.imem_addr = fpc_q;
  assign bus.cpc       = fpc_q;
  assign bus.data      = bus.imem_valid ? bus.imem_data : 32'h0000_0000;
  assign bus.bpc       = bpc_q;
  assign bus.bf        = bf_q;
  assign bus.sel_en    = (state_q == ST_RUN) & bus.imem_valid & ~bus.stall & ~bus.redirect;

  // Next fetch PC, buffer contents and state from redirect/stall/selector decision
  always_comb begin
    fpc_d   = fpc_q;
    bpc_d   = bpc_q;
    bf_d    = bf_q;
    state_d = state_q;
    if (bus.redirect) begin
      // Flush the buffer and restart on a word-aligned target
      fpc_d   = bus.redirect_pc & 32'hFFFF_FFFC;
      bpc_d   = 32'h0000_0000;
      bf_d    = 32'h0000_0000;
      state_d = ST_FILL;
    end else if (adv) begin
      case (state_q)
        ST_FILL: begin
          // A fetched zero word simply leaves the buffer reading as empty
          bpc_d   = fpc_q;
          bf_d    = bus.imem_data;
          fpc_d   = fpc_q + 32'd4;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          case (bus.result)
            RES_POP_BUF, RES_INSERT_NOP: begin
              // Buffered word leaves; the fresh word takes its place
              bpc_d = fpc_q;
              bf_d  = bus.imem_data;
              fpc_d = fpc_q + 32'd4;
            end
            RES_POP_DATA: begin
              fpc_d = fpc_q + 32'd4;
              if (bus.req) begin
                // Buffer empty: take one bubble to refill it
                bpc_d   = 32'h0000_0000;
                bf_d    = 32'h0000_0000;
                state_d = ST_FILL;
              end else begin
                bpc_d = bpc_q;
                bf_d  = bf_q;
              end
            end
            default: begin
              fpc_d = fpc_q;
            end
          endcase
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end else begin
      fpc_d = fpc_q;
    end
  end

  // State and datapath registers; reset discards buffer and pending fill at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q   <= RESET_PC;
      bpc_q   <= 32'h0000_0000;
      bf_q    <= 32'h0000_0000;
      state_q <= ST_FILL;
    end else begin
      fpc_q   <= fpc_d;
      bpc_q   <= bpc_d;
      bf_q    <= bf_d;
      state_q <= state_d;
    end
  end

  fetch_buffer_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .in_run (state_q == ST_RUN),
    .adv    (adv),
    .result (bus.result)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a driver issues one vector per cycle and
// queues the hand-computed expected outputs; a monitor pops and compares
// mid-cycle.

module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam logic [1:0] NOP  = RES_INSERT_NOP;
  localparam logic [1:0] POPD = RES_POP_DATA;
  localparam logic [1:0] POPB = RES_POP_BUF;

  typedef struct {
    int          idx;
    logic [31:0] cpc;
    logic [31:0] data;
    logic [31:0] bpc;
    logic [31:0] bf;
    logic        sel;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   vec_n;
  exp_t exp_q[$];
  exp_t mon_e;

  fetch_buffer_if fb_if ();

  fetch_buffer #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input int idx, input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL vec%0d %s got=%h want=%h", idx, nm, got, want);
    end
  endtask

  // Monitor: compare DUT outputs with the queued expectation each mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk32(mon_e.idx, "cpc", fb_if.cpc, mon_e.cpc);
      chk32(mon_e.idx, "imem_addr", fb_if.imem_addr, mon_e.cpc);
      chk32(mon_e.idx, "data", fb_if.data, mon_e.data);
      chk32(mon_e.idx, "bpc", fb_if.bpc, mon_e.bpc);
      chk32(mon_e.idx, "bf", fb_if.bf, mon_e.bf);
      chk32(mon_e.idx, "sel_en", {31'd0, fb_if.sel_en}, {31'd0, mon_e.sel});
    end
  end

  task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                      input logic v, input logic [31:0] d, input logic [1:0] res, input logic rq,
                      input logic [31:0] ec, input logic [31:0] ed, input logic [31:0] eb,
                      input logic [31:0] ebf, input logic es);
    exp_t e;
    @(posedge clk);
    #1;
    fb_if.stall       = st;
    fb_if.redirect    = rd;
    fb_if.redirect_pc = rpc;
    fb_if.imem_valid  = v;
    fb_if.imem_data   = d;
    fb_if.result      = res;
    fb_if.req         = rq;
    vec_n++;
    e.idx  = vec_n;
    e.cpc  = ec;
    e.data = ed;
    e.bpc  = eb;
    e.bf   = ebf;
    e.sel  = es;
    exp_q.push_back(e);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vec_n = 0;
    rst   = 1'b1;
    fb_if.stall       = 1'b0;
    fb_if.redirect    = 1'b0;
    fb_if.redirect_pc = 32'h0;
    fb_if.imem_valid  = 1'b0;
    fb_if.imem_data   = 32'h0;
    fb_if.result      = POPB;
    fb_if.req         = 1'b0;

    //    st    rd    rpc           v     data          res   rq     cpc           data          bpc           bf            sel
    // Reset state, then FILL from 0
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'h8C01_0000, POPB, 1'b0, 32'h0000_0000, 32'h8C01_0000, 32'h0,        32'h0,        1'b0);
    rst = 1'b0;
    // First selectable cycle, then POP_BUF x3
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'h0022_1820, POPB, 1'b0, 32'h0000_0004, 32'h0022_1820, 32'h0,        32'h8C01_0000, 1'b1);
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0008, POPB, 1'b0, 32'h0000_0008, 32'hA000_0008, 32'h4,        32'h0022_1820, 1'b1);
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_000C, POPB, 1'b0, 32'h0000_000C, 32'hA000_000C, 32'h8,        32'hA000_0008, 1'b1);
    // Redirect to 0x20, fill buffer with 0x12345678
    step(1'b0, 1'b1, 32'h20,       1'b1, 32'hA000_0010, POPB, 1'b0, 32'h0000_0010, 32'hA000_0010, 32'hC,        32'hA000_000C, 1'b0);
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'h1234_5678, POPB, 1'b0, 32'h0000_0020, 32'h1234_5678, 32'h0,        32'h0,        1'b0);
    // POP_DATA holds buffer; req=1 drops back to FILL
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hB000_0024, POPD, 1'b0, 32'h0000_0024, 32'hB000_0024, 32'h20,       32'h1234_5678, 1'b1);
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hB000_0028, POPD, 1'b0, 32'h0000_0028, 32'hB000_0028, 32'h20,       32'h1234_5678, 1'b1);
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hB000_002C, POPD, 1'b1, 32'h0000_002C, 32'hB000_002C, 32'h20,       32'h1234_5678, 1'b1);
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hB000_0030, POPB, 1'b0, 32'h0000_0030, 32'hB000_0030, 32'h0,        32'h0,        1'b0);
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hB000_0034, POPB, 1'b0, 32'h0000_0034, 32'hB000_0034, 32'h30,       32'hB000_0030, 1'b1);
    // Stall x3 with toggling result, then redirect under stall
    step(1'b1, 1'b0, 32'h0,        1'b1, 32'hB000_0038, POPD, 1'b1, 32'h0000_0038, 32'hB000_0038, 32'h34,       32'hB000_0034, 1'b0);
    step(1'b1, 1'b0, 32'h0,        1'b1, 32'hB000_0038, POPB, 1'b0, 32'h0000_0038, 32'hB000_0038, 32'h34,       32'hB000_0034, 1'b0);
    step(1'b1, 1'b0, 32'h0,        1'b1, 32'hB000_0038, NOP,  1'b1, 32'h0000_0038, 32'hB000_0038, 32'h34,       32'hB000_0034, 1'b0);
    step(1'b1, 1'b1, 32'h103,      1'b1, 32'hB000_0038, POPB, 1'b0, 32'h0000_0038, 32'hB000_0038, 32'h34,       32'hB000_0034, 1'b0);
    // imem wait in FILL
    step(1'b0, 1'b0, 32'h0,        1'b0, 32'hDEAD_BEEF, POPB, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        32'h0,        1'b0);
    step(1'b0, 1'b0, 32'h0,        1'b0, 32'hDEAD_BEEF, POPB, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        32'h0,        1'b0);
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hC000_0100, POPB, 1'b0, 32'h0000_0100, 32'hC000_0100, 32'h0,        32'h0,        1'b0);
    // imem wait in RUN, then INSERT_NOP and POP_DATA
    step(1'b0, 1'b0, 32'h0,        1'b0, 32'hDEAD_BEEF, POPB, 1'b0, 32'h0000_0104, 32'h0,        32'h100,      32'hC000_0100, 1'b0);
    step(1'b0, 1'b0, 32'h0,        1'b0, 32'hDEAD_BEEF, POPB, 1'b0, 32'h0000_0104, 32'h0,        32'h100,      32'hC000_0100, 1'b0);
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hC000_0104, NOP,  1'b0, 32'h0000_0104, 32'hC000_0104, 32'h100,      32'hC000_0100, 1'b1);
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hC000_0108, POPD, 1'b0, 32'h0000_0108, 32'hC000_0108, 32'h104,      32'hC000_0104, 1'b1);
    // Redirect near the top of the address space, then wrap via POP_DATA
    step(1'b0, 1'b1, 32'hFFFF_FFFA, 1'b1, 32'hC000_010C, POPD, 1'b0, 32'h0000_010C, 32'hC000_010C, 32'h104,      32'hC000_0104, 1'b0);
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hD000_00F8, POPD, 1'b0, 32'hFFFF_FFF8, 32'hD000_00F8, 32'h0,        32'h0,        1'b0);
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hD000_00FC, POPD, 1'b0, 32'hFFFF_FFFC, 32'hD000_00FC, 32'hFFFF_FFF8, 32'hD000_00F8, 1'b1);
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hD000_0000, POPB, 1'b0, 32'h0000_0000, 32'hD000_0000, 32'hFFFF_FFF8, 32'hD000_00F8, 1'b1);
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hD000_0004, POPB, 1'b0, 32'h0000_0004, 32'hD000_0004, 32'h0,        32'hD000_0000, 1'b1);
    // Reset mid-RUN: outputs return to reset values within the cycle
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hE000_0008, POPB, 1'b0, 32'h0000_0000, 32'hE000_0008, 32'h0,        32'h0,        1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hE000_0000, POPB, 1'b0, 32'h0000_0000, 32'hE000_0000, 32'h0,        32'h0,        1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0, 32'h0,        1'b1, 32'hE000_0004, POPB, 1'b0, 32'h0000_0004, 32'hE000_0004, 32'h0,        32'hE000_0000, 1'b1);

    // Bounded drain of the scoreboard
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
